// File: rtl/apb3_master_pkg.sv
// Shared types and constants for the APB3 request master: FSM states, response codes
// and the width helper for the ACCESS-phase timeout counter.
package apb3_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] RSP_OK       = 2'd0;
    localparam logic [1:0] RSP_SLVERR   = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT  = 2'd2;
    localparam logic [1:0] RSP_MISALIGN = 2'd3;

    // Counter only has to reach cycles-1; keep at least one bit when disabled or tiny.
    function automatic int tmo_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/apb3_req_master.sv
// Valid/ready request -> APB3 SETUP/ACCESS master, one transfer outstanding; response 3 cycles after accept at zero wait.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until rsp_ready.
module apb3_req_master
    import apb3_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] M_PADDR,
    output logic              M_PSEL,
    output logic              M_PENABLE,
    output logic              M_PWRITE,
    output logic [DATA_W-1:0] M_PWDATA,
    input  logic [DATA_W-1:0] M_PRDATA,
    input  logic              M_PREADY,
    input  logic              M_PSLVERR
);

    localparam int               TMO_W    = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        code_q, code_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              enter_err;

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        tmo_d     = tmo_q;
        rdata_d   = rdata_q;
        code_d    = code_q;
        err_cnt_d = err_cnt_q;
        enter_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    if (req_addr[1:0] != 2'b00) begin
                        state_d   = ST_RESP;
                        code_d    = RSP_MISALIGN;
                        rdata_d   = '0;
                        enter_err = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                tmo_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY is checked first so a late ready still completes normally.
                if (M_PREADY) begin
                    state_d   = ST_RESP;
                    code_d    = M_PSLVERR ? RSP_SLVERR : RSP_OK;
                    rdata_d   = (pwrite_q || M_PSLVERR) ? '0 : M_PRDATA;
                    enter_err = M_PSLVERR;
                end else if (TIMEOUT_CYCLES > 0 && tmo_q == TMO_LAST) begin
                    state_d   = ST_RESP;
                    code_d    = RSP_TIMEOUT;
                    rdata_d   = '0;
                    enter_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            tmo_q     <= '0;
            rdata_q   <= '0;
            code_q    <= RSP_OK;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            tmo_q     <= tmo_d;
            rdata_q   <= rdata_d;
            code_q    <= code_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Bus strobes decode straight from the state flop so reset drops them without a clock.
    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign M_PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign M_PENABLE   = (state_q == ST_ACCESS);
    assign M_PADDR     = paddr_q;
    assign M_PWRITE    = pwrite_q;
    assign M_PWDATA    = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = (code_q != RSP_OK);
    assign rsp_timeout = (code_q == RSP_TIMEOUT);
    assign err_count   = err_cnt_q;

endmodule

// File: doc/apb3_req_master.md
Name: apb3_req_master

Overview:
- Upstream APB3 master stage that drives the APB3mmaster slave port of the User_Interfaces subsystem (UART, GPIO, timer, SD and SPI-flash SPI).
- Converts a simple valid/ready request/response interface, from fabric logic such as a boot loader or a command sequencer, into compliant APB3 SETUP/ACCESS cycles.
- Handles wait states, PSLVERR, misaligned requests and hung slaves (timeout).
- Runs one outstanding transfer at a time.

Parameters:
- ADDR_W, 32, width of request address and M_PADDR.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles waiting for M_PREADY before abort; 0 disables the timeout.
- CNT_W, 8, width of the saturating error counter.

Ports:
- PCLK  in  1  single clock; all logic is rising-edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  transfer failed (PSLVERR, timeout or misalignment).
- rsp_timeout  out  1  failure was a timeout.
- err_count  out  CNT_W  saturating count of error responses.
- M_PADDR  out  ADDR_W  APB address.
- M_PSEL  out  1  APB select.
- M_PENABLE  out  1  APB enable.
- M_PWRITE  out  1  APB direction.
- M_PWDATA  out  DATA_W  APB write data.
- M_PRDATA  in  DATA_W  APB read data.
- M_PREADY  in  1  APB ready.
- M_PSLVERR  in  1  APB slave error.

Behaviour:
- Reset:
  - State is IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, err_count=0.
  - M_PSEL=0, M_PENABLE=0, M_PADDR=0, M_PWRITE=0, M_PWDATA=0.
  - Reset asserted mid-transfer drops M_PSEL/M_PENABLE immediately (asynchronous), abandons the transfer and produces no response.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1 in IDLE only.
  - On handshake, register addr/write/wdata into M_PADDR/M_PWRITE/M_PWDATA and go to SETUP.
  - If req_addr[1:0]!=0, skip the bus: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- SETUP (1 cycle): M_PSEL=1, M_PENABLE=0; clear the timeout counter; go to ACCESS.
- ACCESS:
  - M_PSEL=1, M_PENABLE=1.
  - While M_PREADY=0, increment the timeout counter.
  - On M_PREADY=1, capture M_PRDATA (reads only) and M_PSLVERR into rsp_err; go to RESP.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with M_PREADY still 0, abort: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - M_PREADY and timeout in the same cycle: M_PREADY wins.
- RESP:
  - M_PSEL=0, M_PENABLE=0, rsp_valid=1.
  - Response fields are held stable until rsp_ready, then go to IDLE.
  - rsp_ready may already be high on entry; the response is then consumed in its first RESP cycle.
- Latency:
  - Handshake at cycle 0, M_PSEL at cycle 1, M_PENABLE at cycle 2.
  - With zero wait states, rsp_valid is seen at cycle 3.
  - Back-to-back throughput is 4 cycles per transfer when rsp_ready is held high.
- M_PADDR/M_PWRITE/M_PWDATA:
  - Stable for the whole SETUP+ACCESS phase.
  - Hold their last value in IDLE/RESP; they change only on request accept.
- err_count increments by 1 at each entry to RESP with rsp_err=1; it saturates at 2^CNT_W-1 and never wraps.
- M_PENABLE is never 1 without M_PSEL; M_PSEL never asserts outside SETUP/ACCESS.

Decomposition:
- Shared package apb3_master_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - a clog2-based width function for the timeout counter;
  - response error code constants (OK, SLVERR, TIMEOUT, MISALIGN).
- No sub-module; the FSM, timeout counter and error counter live in one module.

Test Plan:
- Read 0x0000_0004, M_PREADY=1 in first ACCESS, M_PRDATA=0xDEADBEEF -> M_PSEL at cycle 1, M_PENABLE at cycle 2, rsp_valid at cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write 0x1000_0000 data 0x55, slave inserts 3 wait states -> M_PADDR/M_PWDATA stable for all 5 PSEL cycles, rsp_valid 3 cycles later than the zero-wait case, rsp_rdata=0.
- M_PSLVERR=1 with M_PREADY on a read -> rsp_err=1, rsp_timeout=0, err_count 0->1.
- TIMEOUT_CYCLES=16, slave never ready -> M_PSEL drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; the next request completes normally.
- Request at addr 0x0000_0002 -> no M_PSEL pulse, rsp_err=1, rsp_timeout=0; also hold rsp_ready=0 for 5 cycles and check that req_ready stays 0 and the response stays stable.
- PRESET pulse during ACCESS -> M_PSEL/M_PENABLE go 0 without a clock edge, no rsp_valid, err_count=0; drive 300 errors with CNT_W=8 -> err_count holds at 255.
